// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: bus widths, halt opcode and fetch FSM encoding.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int OP_W   = 6;
  localparam logic [OP_W-1:0] HALT_OP_DEF = 6'b001111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Program-memory read port plus the ir handshake and redirect toward decode.
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ce;
  logic                  mem_rw;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] ir;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  jmp_en;
  logic [ADDR_WIDTH-1:0] jmp_addr;

  modport master (
    output mem_addr, mem_ce, mem_rw, ir, ir_valid,
    input  mem_data, ir_ready, jmp_en, jmp_addr
  );

  modport slave (
    input  mem_addr, mem_ce, mem_rw, ir, ir_valid,
    output mem_data, ir_ready, jmp_en, jmp_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads program memory at pc, presents words on ir with a
// valid/ready handshake, follows redirects and stops on the halt opcode.
//
// state | meaning
// IDLE  | waiting for start, memory idle
// REQ   | address phase, chip enable asserted
// WAIT  | registered read data returns; captured into ir on exit
// HOLD  | ir valid, waiting for decode to accept
// HALT  | halt instruction accepted; only clr leaves
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_WIDTH = ADDR_W,
  parameter int              DATA_WIDTH = DATA_W,
  parameter logic [OP_W-1:0] HALT_OP    = HALT_OP_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  instr_fetch_if.master         bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic                  is_halt;
  logic                  handshake;

  assign is_halt   = (ir_q[DATA_WIDTH-1 -: OP_W] == HALT_OP);
  assign handshake = (state_q == HOLD) && bus.ir_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    state_d = HOLD;
      HOLD:    if (bus.ir_ready) state_d = is_halt ? HALT : REQ;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // pc advances when the word is captured, so a redirect on accept overrides it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc   <= '0;
      ir_q <= '0;
    end else if (state_q == WAIT) begin
      ir_q <= bus.mem_data;
      pc   <= pc + 1'b1;
    end else if (handshake && bus.jmp_en && !is_halt) begin
      pc <= bus.jmp_addr;
    end
  end

  assign bus.mem_addr = pc;
  assign bus.mem_ce   = (state_q == REQ) || (state_q == WAIT);
  assign bus.mem_rw   = 1'b1;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = (state_q == HOLD);
  assign halted       = (state_q == HALT);

endmodule
